// File: rtl/sqrt_arbiter_if.sv
// Bundle of requester-side and sqrt-unit-side signals around the arbiter.
// slave is the arbiter's view; master is the surrounding environment's view.
interface sqrt_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
);
  logic [N_REQ-1:0]    req_bi;
  logic [16*N_REQ-1:0] a_bi;
  logic [N_REQ-1:0]    ack_bo;
  logic [7:0]          y_bo;
  logic [ID_W-1:0]     grant_id_bo;
  logic                busy_o;
  logic                sq_start_o;
  logic [15:0]         sq_a_bo;
  logic                sq_busy_i;
  logic [7:0]          sq_y_bi;

  modport slave (
    input  req_bi, a_bi, sq_busy_i, sq_y_bi,
    output ack_bo, y_bo, grant_id_bo, busy_o, sq_start_o, sq_a_bo
  );

  modport master (
    output req_bi, a_bi, sq_busy_i, sq_y_bi,
    input  ack_bo, y_bo, grant_id_bo, busy_o, sq_start_o, sq_a_bo
  );
endinterface

// File: rtl/sqrt_arbiter.sv
// Round-robin sharing of a single sqrt unit among N_REQ requesters.
// One operation in flight; every output is a flop.
//
//  state       | meaning
//  ------------+-----------------------------------------------------------
//  S_IDLE      | arbitrate from last_ptr+1, latch winner's operand
//  S_ISSUE     | sq_start_o high for this single cycle
//  S_WAIT_BUSY | wait for the unit to raise sq_busy_i
//  S_WAIT_DONE | wait for sq_busy_i low, capture the root
//  S_RESP      | one-cycle ack to the granted requester
module sqrt_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input logic           clk_i,
  input logic           rst_i,
  sqrt_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_RESP
  } state_t;

  state_t           state, state_nxt;
  logic [ID_W-1:0]  last_ptr, last_ptr_nxt;
  logic [ID_W-1:0]  grant, grant_nxt;
  logic [15:0]      sq_a, sq_a_nxt;
  logic [7:0]       y, y_nxt;
  logic [N_REQ-1:0] ack, ack_nxt;
  logic             start, start_nxt;
  logic             busy, busy_nxt;

  logic [ID_W-1:0]  pick;
  logic [ID_W-1:0]  cand;
  logic             pick_valid;

  // Scan offsets from farthest to nearest so the nearest set bit after
  // last_ptr is the one left standing.
  always_comb begin
    pick       = '0;
    cand       = '0;
    pick_valid = 1'b0;
    for (int i = N_REQ; i >= 1; i--) begin
      cand = ID_W'((int'(last_ptr) + i) % N_REQ);
      if (bus.req_bi[cand]) begin
        pick       = cand;
        pick_valid = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    last_ptr_nxt = last_ptr;
    grant_nxt    = grant;
    sq_a_nxt     = sq_a;
    y_nxt        = y;
    ack_nxt      = '0;
    start_nxt    = 1'b0;
    busy_nxt     = 1'b1;
    case (state)
      S_IDLE: begin
        busy_nxt = pick_valid;
        if (pick_valid) begin
          state_nxt    = S_ISSUE;
          grant_nxt    = pick;
          last_ptr_nxt = pick;
          sq_a_nxt     = bus.a_bi[int'(pick)*16 +: 16];
          start_nxt    = 1'b1;
        end
      end
      S_ISSUE: begin
        state_nxt = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (bus.sq_busy_i) state_nxt = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (!bus.sq_busy_i) begin
          state_nxt      = S_RESP;
          y_nxt          = bus.sq_y_bi;
          ack_nxt[grant] = 1'b1;
        end
      end
      S_RESP: begin
        state_nxt = S_IDLE;
        busy_nxt  = 1'b0;
      end
      default: begin
        state_nxt = S_IDLE;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= S_IDLE;
      last_ptr <= ID_W'(N_REQ - 1);
      grant    <= '0;
      sq_a     <= '0;
      y        <= '0;
      ack      <= '0;
      start    <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      last_ptr <= last_ptr_nxt;
      grant    <= grant_nxt;
      sq_a     <= sq_a_nxt;
      y        <= y_nxt;
      ack      <= ack_nxt;
      start    <= start_nxt;
      busy     <= busy_nxt;
    end
  end

  assign bus.ack_bo      = ack;
  assign bus.y_bo        = y;
  assign bus.grant_id_bo = grant;
  assign bus.busy_o      = busy;
  assign bus.sq_start_o  = start;
  assign bus.sq_a_bo     = sq_a;

endmodule

// File: tb/tb_sqrt_arbiter.sv
// Directed bench for sqrt_arbiter with a behavioural sqrt unit (busy for B cycles).
// Requesters drop their bit on ack; sticky requesters re-raise it the cycle after.
module tb_sqrt_arbiter;

  localparam int N_REQ = 4;
  localparam int ID_W  = 2;
  localparam int B     = 3;

  logic clk;
  logic rst;

  sqrt_arbiter_if #(.N_REQ(N_REQ), .ID_W(ID_W)) bus ();

  sqrt_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] isqrt(input logic [15:0] v);
    int r;
    int t;
    r = 0;
    for (int b = 7; b >= 0; b--) begin
      t = r | (1 << b);
      if (t * t <= int'(v)) r = t;
    end
    return 8'(r);
  endfunction

  int sq_cnt;
  always @(posedge clk) begin
    if (rst) begin
      bus.sq_busy_i <= 1'b0;
      bus.sq_y_bi   <= 8'd0;
      sq_cnt        <= 0;
    end else if (bus.sq_start_o) begin
      bus.sq_busy_i <= 1'b1;
      bus.sq_y_bi   <= isqrt(bus.sq_a_bo);
      sq_cnt        <= B;
    end else if (bus.sq_busy_i) begin
      if (sq_cnt == 1) bus.sq_busy_i <= 1'b0;
      sq_cnt <= sq_cnt - 1;
    end
  end

  int errors = 0;
  int checks = 0;

  logic [N_REQ-1:0] sticky = '0;
  logic [N_REQ-1:0] pend   = '0;
  logic [N_REQ-1:0] prev_ack = '0;
  int ack_id_q[$];
  int ack_y_q[$];
  int ack_cyc_q[$];
  int start_busy_viol = 0;
  int ack_wide_viol   = 0;
  int ack_multi_viol  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    int id;
    @(negedge clk);
    bus.req_bi = bus.req_bi | pend;
    pend = '0;
    if (bus.sq_start_o && bus.sq_busy_i) start_busy_viol++;
    if (bus.ack_bo != '0) begin
      if (prev_ack != '0) ack_wide_viol++;
      if (!$onehot(bus.ack_bo)) ack_multi_viol++;
      id = -1;
      for (int k = 0; k < N_REQ; k++) if (bus.ack_bo[k]) id = k;
      ack_id_q.push_back(id);
      ack_y_q.push_back(int'(bus.y_bo));
      ack_cyc_q.push_back(cyc);
      pend = bus.ack_bo & sticky;
      bus.req_bi = bus.req_bi & ~bus.ack_bo;
    end
    prev_ack = bus.ack_bo;
  endtask

  task automatic wait_acks(input string tag, input int n);
    int target;
    int t;
    target = ack_id_q.size() + n;
    t = 0;
    while (ack_id_q.size() < target && t < 200) begin
      step();
      t++;
    end
    check({tag, "_ack_seen"}, ack_id_q.size() >= target, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    pend = '0;
    prev_ack = '0;
  endtask

  task automatic single_op(input string tag, input int k, input logic [15:0] a, input int exp_y);
    int n0;
    int lat;
    n0 = ack_id_q.size();
    bus.a_bi[16*k +: 16] = a;
    bus.req_bi[k] = 1'b1;
    lat = 0;
    while (ack_id_q.size() == n0 && lat < 40) begin
      step();
      lat++;
    end
    check({tag, "_latency"}, lat, B + 3);
    if (ack_id_q.size() > n0) begin
      check({tag, "_id"}, ack_id_q[n0], k);
      check({tag, "_y"}, ack_y_q[n0], exp_y);
    end
    step();
    step();
  endtask

  int n0;
  int fair_id[7];
  int fair_y[7];

  initial begin
    rst        = 1'b1;
    bus.req_bi = '0;
    bus.a_bi   = '0;
    do_reset();

    // reset state
    check("rst_ack",   bus.ack_bo, 0);
    check("rst_y",     bus.y_bo, 0);
    check("rst_grant", bus.grant_id_bo, 0);
    check("rst_busy",  bus.busy_o, 0);
    check("rst_start", bus.sq_start_o, 0);
    check("rst_sq_a",  bus.sq_a_bo, 0);

    // single request, cycle by cycle
    n0 = ack_id_q.size();
    bus.a_bi[15:0] = 16'd25;
    bus.req_bi = 4'b0001;
    step();
    check("t1_start", bus.sq_start_o, 1);
    check("t1_sq_a",  bus.sq_a_bo, 25);
    check("t1_busy",  bus.busy_o, 1);
    check("t1_grant", bus.grant_id_bo, 0);
    step();
    check("t1_start_one_cycle", bus.sq_start_o, 0);
    repeat (3) step();
    check("t1_no_early_ack", ack_id_q.size(), n0);
    step();
    check("t1_ack", bus.ack_bo, 4'b0001);
    check("t1_y",   bus.y_bo, 5);
    step();
    check("t1_ack_drop", bus.ack_bo, 0);
    check("t1_idle_busy", bus.busy_o, 0);
    check("t1_y_hold", bus.y_bo, 5);

    // simultaneous requests after reset
    do_reset();
    n0 = ack_id_q.size();
    bus.a_bi = {16'd16, 16'd9, 16'd2, 16'd1};
    bus.req_bi = 4'b1111;
    wait_acks("t2", 4);
    if (ack_id_q.size() >= n0 + 4) begin
      check("t2_id0", ack_id_q[n0],   0);
      check("t2_id1", ack_id_q[n0+1], 1);
      check("t2_id2", ack_id_q[n0+2], 2);
      check("t2_id3", ack_id_q[n0+3], 3);
      check("t2_y0",  ack_y_q[n0],    1);
      check("t2_y1",  ack_y_q[n0+1],  1);
      check("t2_y2",  ack_y_q[n0+2],  3);
      check("t2_y3",  ack_y_q[n0+3],  4);
      check("t2_gap01", ack_cyc_q[n0+1] - ack_cyc_q[n0],   B + 4);
      check("t2_gap23", ack_cyc_q[n0+3] - ack_cyc_q[n0+2], B + 4);
    end
    repeat (2) step();

    // fairness: 0 and 2 keep re-requesting, 3 joins after the third result
    n0 = ack_id_q.size();
    bus.a_bi = {16'd100, 16'd36, 16'd0, 16'd4};
    sticky = 4'b0101;
    bus.req_bi = 4'b0101;
    wait_acks("t3a", 3);
    bus.req_bi[3] = 1'b1;
    wait_acks("t3b", 4);
    sticky = '0;
    pend = '0;
    bus.req_bi = '0;
    repeat (3) step();
    fair_id = '{0, 2, 0, 2, 3, 0, 2};
    fair_y  = '{2, 6, 2, 6, 10, 2, 6};
    if (ack_id_q.size() >= n0 + 7) begin
      for (int i = 0; i < 7; i++) begin
        check($sformatf("t3_id%0d", i), ack_id_q[n0+i], fair_id[i]);
        check($sformatf("t3_y%0d", i),  ack_y_q[n0+i],  fair_y[i]);
      end
    end

    // operand width extremes
    single_op("t4_ffff", 1, 16'hFFFF, 255);
    single_op("t4_zero", 2, 16'h0000, 0);
    single_op("t4_two",  3, 16'h0002, 1);

    // reset during WAIT_DONE
    n0 = ack_id_q.size();
    bus.a_bi[47:32] = 16'd49;
    bus.req_bi[2] = 1'b1;
    repeat (4) step();
    rst = 1'b1;
    bus.req_bi = '0;
    step();
    check("t5_ack",   bus.ack_bo, 0);
    check("t5_y",     bus.y_bo, 0);
    check("t5_grant", bus.grant_id_bo, 0);
    check("t5_busy",  bus.busy_o, 0);
    check("t5_start", bus.sq_start_o, 0);
    check("t5_sq_a",  bus.sq_a_bo, 0);
    rst = 1'b0;
    repeat (8) step();
    check("t5_no_ack", ack_id_q.size(), n0);
    single_op("t5_after", 1, 16'd144, 12);

    // requester 1 drops its request while the unit is starting
    do_reset();
    n0 = ack_id_q.size();
    bus.a_bi = {16'd0, 16'd121, 16'd81, 16'd0};
    bus.req_bi = 4'b0110;
    step();
    check("t6_grant", bus.grant_id_bo, 1);
    check("t6_sq_a",  bus.sq_a_bo, 81);
    step();
    bus.req_bi[1] = 1'b0;
    wait_acks("t6", 2);
    if (ack_id_q.size() >= n0 + 2) begin
      check("t6_id0", ack_id_q[n0],   1);
      check("t6_y0",  ack_y_q[n0],    9);
      check("t6_id1", ack_id_q[n0+1], 2);
      check("t6_y1",  ack_y_q[n0+1],  11);
    end
    repeat (10) step();
    check("t6_no_extra_ack", ack_id_q.size(), n0 + 2);
    check("t6_idle", bus.busy_o, 0);

    check("start_while_busy", start_busy_viol, 0);
    check("ack_width",        ack_wide_viol, 0);
    check("ack_onehot",       ack_multi_viol, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sqrt_arbiter.md
# sqrt_arbiter

Round-robin controller that shares one `sqrt` unit (16-bit operand, 8-bit integer root) among `N_REQ` requesters. It grants one requester at a time, latches that requester's operand and sequences the unit's start/busy handshake. It then returns the root to the granted requester with a one-cycle acknowledge. It sits between the requester ports and a single `sqrt` instance, and that instance shares `clk_i`/`rst_i` with this block.

## Interface
- `N_REQ`, 4: number of requesters; 2..2^`ID_W`.
- `ID_W`, 2: width of the grant index.
- `clk_i` in 1: clock; all logic updates on the rising edge.
- `rst_i` in 1: reset, synchronous, active-high.
- `req_bi` in `N_REQ`: level request; bit k held high until `ack_bo[k]`.
- `a_bi` in 16·`N_REQ`: packed operands; requester k uses `[16k+15:16k]`; must be stable while `req_bi[k]` is high.
- `ack_bo` out `N_REQ`: one-hot, one-cycle pulse; `y_bo` is valid for that requester in the same cycle.
- `y_bo` out 8: shared result bus; holds its last value between acks.
- `grant_id_bo` out `ID_W`: index of the requester currently or last served.
- `busy_o` out 1: high in every state except IDLE.
- `sq_start_o` out 1: start pulse to the sqrt unit.
- `sq_a_bo` out 16: operand to the sqrt unit; held from ISSUE through WAIT_DONE.
- `sq_busy_i` in 1: sqrt unit busy.
- `sq_y_bi` in 8: sqrt unit root; valid once `sq_busy_i` falls.

## Operation
- **Reset values.** `ack_bo`=0, `y_bo`=0, `grant_id_bo`=0, `busy_o`=0, `sq_start_o`=0, `sq_a_bo`=0, state IDLE, `last_ptr`=`N_REQ`-1 (requester 0 wins first).
- **IDLE.** If any `req_bi` bit is high, pick the first set bit searching `last_ptr`+1, +2, … with wrap modulo `N_REQ`. Register its index into `grant_id_bo` and `last_ptr`, latch its operand into `sq_a_bo`, and go to ISSUE. With no requests, stay in IDLE.
- **ISSUE.** `sq_start_o`=1 for exactly this one cycle, then go to WAIT_BUSY.
- **WAIT_BUSY.** Wait for `sq_busy_i`=1, then go to WAIT_DONE.
  - If `sq_busy_i` is already high in the ISSUE cycle, WAIT_BUSY still lasts at least one cycle.
- **WAIT_DONE.** On the first cycle with `sq_busy_i`=0, capture `sq_y_bi` into `y_bo` and go to RESP.
- **RESP.** `ack_bo[grant_id_bo]`=1 for this one cycle, then go to IDLE.
- **Arbitration.** Only IDLE arbitrates, so there is exactly one operation in flight. Requests that arrive or change in other states are ignored until the next IDLE.
- **Dropped request.** If `req_bi[k]` falls after grant, the operation still completes and the ack is still pulsed; the requester ignores it.
- **Request after ack.** The requester must drop `req_bi[k]` in the cycle after its ack. If it is still high in the following IDLE, it counts as a new request, but at lowest round-robin priority.
- **Operand width.** `sq_a_bo` is the full 16 bits, with no truncation. Roots range 0..255 (0xFFFF → 255).
- **Reset mid-operation.** Any state goes to IDLE with reset values. No ack is produced for the aborted request, and `last_ptr` reinitialises.

## Timing
- Let `req_bi[k]` be sampled high in IDLE at cycle 0, with the bus otherwise idle:
  - ISSUE (`sq_start_o`=1) at cycle 1;
  - WAIT_BUSY from cycle 2;
  - if the unit raises busy at cycle 2 and holds it for B cycles, `sq_busy_i` is low again at cycle 2+B, which is the last WAIT_DONE cycle;
  - RESP/ack at cycle 3+B.
- Total latency is B+3 cycles from the sampled request to the ack.
- The next grant comes from the IDLE at cycle 4+B. Back-to-back throughput is one result per B+4 cycles.
- `busy_o` is high from cycle 1 through cycle 3+B.
- All outputs are registered; there is no combinational path from `req_bi` or `sq_*_i` to any output.

## Test plan
- **Single request.** Only `req_bi[0]`, a=25 → `sq_start_o` pulse with `sq_a_bo`=25; `ack_bo`=0001 and `y_bo`=5 exactly B+3 cycles after the request is sampled.
- **Simultaneous requests after reset.** `req_bi`=1111, operands 1, 2, 9, 16 → acks in order 0, 1, 2, 3 with `y_bo`=1, 1, 3, 4. Each ack is one cycle wide and `sq_start_o` is never high while `sq_busy_i` is high.
- **Fairness.** `req_bi[0]` and `req_bi[2]` re-raised immediately after each ack for 6 operations → grants alternate 0, 2, 0, 2, 0, 2; requester 3 raised mid-sequence is served within one rotation.
- **Width extremes.** a=0xFFFF → `y_bo`=255; a=0 → `y_bo`=0; a=2 → `y_bo`=1 (floor).
- **Reset mid-operation.** `rst_i` pulsed during WAIT_DONE → next cycle all outputs at reset values, no ack for the aborted request. A subsequent request from requester 1 alone is served normally with the correct root.
- **Dropped request.** `req_bi[1]` falls during WAIT_BUSY → `ack_bo[1]` still pulses once, then the block returns to IDLE and serves other pending requests.
